// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned multiplier built on one time-shared 4x4 Wallace multiplier.
// Optional accumulate mode enabled by macro MUL8_SEQ_ACC_EN.

module mul4_wallace (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);
  logic [3:0] pp [4];
  logic h1s, h1c, f2s, f2c, f3s, f3c, f4s, f4c, h5s, h5c;
  logic s3, c3, s4, c4, s5, c5, s6, c6;
  logic [7:0] row0, row1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = x[i] & y[j];
      end
    end
  end

  // first reduction layer: pp[i][j] carries weight i+j
  assign {h1c, h1s} = pp[0][1] + pp[1][0];
  assign {f2c, f2s} = pp[0][2] + pp[1][1] + pp[2][0];
  assign {f3c, f3s} = pp[0][3] + pp[1][2] + pp[2][1];
  assign {f4c, f4s} = pp[1][3] + pp[2][2] + pp[3][1];
  assign {h5c, h5s} = pp[2][3] + pp[3][2];

  // second layer brings every column down to at most two bits
  assign {c3, s3} = f3s + pp[3][0];
  assign {c4, s4} = f4s + f3c;
  assign {c5, s5} = h5s + f4c;
  assign {c6, s6} = pp[3][3] + h5c;

  assign row0 = {c6, s6, s5, s4, s3, f2s, h1s, pp[0][0]};
  assign row1 = {1'b0, c5, c4, c3, f2c, h1c, 2'b00};
  assign p    = row0 + row1;
endmodule

module mul8_seq #(
  parameter int FAST_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        acc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state;
  logic [1:0]  step;
  logic [7:0]  a_q, b_q;
  logic [15:0] accum;
  logic [15:0] start_val;
  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_shift;
  logic [15:0] sum;
  logic        zero_ops;

`ifdef MUL8_SEQ_ACC_EN
  assign start_val = acc ? prod : 16'h0000;
`else
  logic unused_acc;
  assign unused_acc = acc;
  assign start_val  = 16'h0000;
`endif

  // step[1] selects the high nibble of a, step[0] the high nibble of b
  assign nib_a = step[1] ? a_q[7:4] : a_q[3:0];
  assign nib_b = step[0] ? b_q[7:4] : b_q[3:0];

  mul4_wallace u_mul (
    .x(nib_a),
    .y(nib_b),
    .p(pp)
  );

  always_comb begin
    pp_shift = {8'h00, pp};
    case (step)
      2'd0:    pp_shift = {8'h00, pp};
      2'd1,
      2'd2:    pp_shift = {4'h0, pp, 4'h0};
      default: pp_shift = {pp, 8'h00};
    endcase
  end

  assign sum      = accum + pp_shift;
  assign zero_ops = (a_q == 8'h00) || (b_q == 8'h00);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= 2'd0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      accum     <= 16'h0000;
      prod      <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            step  <= 2'd0;
            accum <= start_val;
            state <= MUL;
          end
        end
        MUL: begin
          if ((FAST_ZERO != 0) && zero_ops) begin
            prod      <= accum;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            accum <= sum;
            step  <= step + 2'd1;
            if (step == 2'd3) begin
              prod      <= sum;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq: vector table, hand sequences and randomized ops vs. a model.

module tb_mul8_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        acc = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        in_ready, out_valid, busy;
  logic [15:0] prod;
  logic        in_ready_nz, out_valid_nz, busy_nz;
  logic [15:0] prod_nz;

  always #5 clk = ~clk;

  mul8_seq #(.FAST_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .acc(acc), .out_valid(out_valid), .out_ready(out_ready),
    .prod(prod), .busy(busy)
  );

  mul8_seq #(.FAST_ZERO(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nz),
    .a(a), .b(b), .acc(acc), .out_valid(out_valid_nz), .out_ready(out_ready),
    .prod(prod_nz), .busy(busy_nz)
  );

`ifdef MUL8_SEQ_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        acc;
    logic [15:0] exp_en;
    logic [15:0] exp_dis;
    int          lat;
    int          hold;
  } vec_t;

  vec_t        tbl [10];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] model_prev = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] ref_prod(input int x, input int y, input bit use_acc, input int prev);
    int r;
    r = x * y;
    if (ACC_EN && use_acc) r = r + prev;
    return 16'(r % 65536);
  endfunction

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tacc,
                        input logic [15:0] exp, input int exp_lat, input int hold, input string tag);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; acc = tacc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // junk operands offered while busy must be ignored
    a = 8'($urandom); b = 8'($urandom); acc = 1'($urandom);
    while (lat < 12) begin
      if (busy) busy_cnt++;
      if (out_valid) break;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " prod"}, 32'(prod), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      chk({tag, " hold"}, {13'd0, out_valid, in_ready, busy, prod}, {13'd0, 1'b1, 1'b0, 1'b1, exp});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat + 1 + hold));
    chk({tag, " consumed"}, {13'd0, out_valid, in_ready, busy, prod}, {13'd0, 1'b0, 1'b1, 1'b0, exp});
  endtask

  initial begin
    int l1, l2;
    bit seen;
    logic [7:0]  ra, rb;
    logic        racc;
    logic [15:0] rexp;

    tbl[0] = '{8'd200, 8'd150, 1'b0, 16'd30000, 16'd30000, 4, 0};
    tbl[1] = '{8'd255, 8'd255, 1'b0, 16'd65025, 16'd65025, 4, 1};
    tbl[2] = '{8'd255, 8'd2,   1'b1, 16'd65535, 16'd510,   4, 0};
    tbl[3] = '{8'd1,   8'd1,   1'b1, 16'd0,     16'd1,     4, 0};
    tbl[4] = '{8'd0,   8'd13,  1'b0, 16'd0,     16'd0,     1, 0};
    tbl[5] = '{8'd16,  8'd16,  1'b0, 16'd256,   16'd256,   4, 0};
    tbl[6] = '{8'd15,  8'd15,  1'b1, 16'd481,   16'd225,   4, 2};
    tbl[7] = '{8'd0,   8'd0,   1'b1, 16'd481,   16'd0,     1, 0};
    tbl[8] = '{8'd128, 8'd255, 1'b1, 16'd33121, 16'd32640, 4, 0};
    tbl[9] = '{8'd7,   8'd0,   1'b1, 16'd33121, 16'd0,     1, 0};

    repeat (2) @(negedge clk);
    chk("reset state", {28'd0, out_valid, in_ready, busy, |prod}, {28'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;

    // zero operand: fast path vs. full path, first transfer after reset
    a = 8'd0; b = 8'd13; acc = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    l1 = -1; l2 = -1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid && l1 < 0) l1 = i;
      if (out_valid_nz && l2 < 0) l2 = i;
      @(negedge clk);
    end
    chk("fast zero latency", 32'(l1), 32'd1);
    chk("full zero latency", 32'(l2), 32'd4);
    chk("fast zero prod", 32'(prod), 32'd0);
    chk("full zero prod", 32'(prod_nz), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("both idle", {30'd0, in_ready, in_ready_nz}, {30'd0, 2'b11});

    for (int i = 0; i < 10; i++) begin
      rexp = ACC_EN ? tbl[i].exp_en : tbl[i].exp_dis;
      run_op(tbl[i].a, tbl[i].b, tbl[i].acc, rexp, tbl[i].lat, tbl[i].hold, $sformatf("vec%0d", i));
      model_prev = rexp;
    end

    run_op(8'd255, 8'd255, 1'b0, 16'hFE01, 4, 3, "hold 255x255");
    model_prev = 16'hFE01;

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) ra = 8'd0;
      if ($urandom_range(0, 7) == 0) rb = 8'd0;
      racc = 1'($urandom_range(0, 1));
      rexp = ref_prod(int'(ra), int'(rb), racc, int'(model_prev));
      run_op(ra, rb, racc, rexp, (ra == 0 || rb == 0) ? 1 : 4, int'($urandom_range(0, 2)),
             $sformatf("rnd%0d", i));
      model_prev = rexp;
    end

    // reset in the middle of an operation
    @(negedge clk);
    a = 8'd17; b = 8'd9; acc = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort state", {13'd0, out_valid, in_ready, busy, prod}, {13'd0, 1'b0, 1'b1, 1'b0, 16'd0});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no out_valid after abort", 32'(seen), 32'd0);
    model_prev = 16'h0000;
    run_op(8'd3, 8'd5, 1'b1, ref_prod(3, 5, 1'b1, int'(model_prev)), 4, 0, "post reset 3x5");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
